// File: rtl/seg_scan_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a double-buffered,
// time-multiplexed common-anode seven-segment scanner with blanking and overflow.
module seg_scan_bcd #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_vld,
  output logic              bin_rdy,
  output logic              ovf,
  output logic [7:0]        seg_led,
  output logic [DIGITS-1:0] seg_sel
);

  localparam int ND    = BIN_W * 3 / 10 + 1;
  localparam int EXT_W = 4 * (ND + DIGITS);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [ND*4-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS*4-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          seg_led_q, seg_led_d;
  logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [EXT_W-1:0]    bcd_ext;
  logic [3:0]          nib;
  logic                hi_nz;

  function automatic logic [7:0] seg_dec(input logic [3:0] n);
    case (n)
      4'd0:    seg_dec = 8'hC0;
      4'd1:    seg_dec = 8'hF9;
      4'd2:    seg_dec = 8'hA4;
      4'd3:    seg_dec = 8'hB0;
      4'd4:    seg_dec = 8'h99;
      4'd5:    seg_dec = 8'h92;
      4'd6:    seg_dec = 8'h82;
      4'd7:    seg_dec = 8'hF8;
      4'd8:    seg_dec = 8'h80;
      4'd9:    seg_dec = 8'h90;
      default: seg_dec = 8'hFF;
    endcase
  endfunction

  // Zero-extended so digits beyond the converter width read as blank zeros.
  assign bcd_ext = EXT_W'(bcd_q);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    bcd_adj = bcd_q;
    for (int n = 0; n < ND; n++) begin
      if (bcd_adj[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_adj[n*4 +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (bin_vld) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_d  = bcd_ext[DIGITS*4-1:0];
        ovf_d   = |bcd_ext[EXT_W-1:DIGITS*4];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nib   = '0;
    hi_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nib = disp_q[i*4 +: 4];
      if (IDX_W'(i) >= idx_q && disp_q[i*4 +: 4] != 4'd0) hi_nz = 1'b1;
    end
    // Overflow dash wins over blanking; digit 0 is never blanked.
    if (ovf_q)
      seg_led_d = 8'hBF;
    else if (BLANK_LZ != 0 && idx_q != '0 && !hi_nz)
      seg_led_d = 8'hFF;
    else
      seg_led_d = seg_dec(nib);
    seg_sel_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      div_q     <= '0;
      idx_q     <= '0;
      seg_led_q <= 8'hC0;
      seg_sel_q <= ~DIGITS'(1);
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_led_q <= seg_led_d;
      seg_sel_q <= seg_sel_d;
    end
  end

  assign bin_rdy = (state_q == S_IDLE);
  assign ovf     = ovf_q;
  assign seg_led = seg_led_q;
  assign seg_sel = seg_sel_q;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Bench for seg_scan_bcd: three instances (default, no blanking, 2 digits) share
// stimulus; expected segments come from a decimal-arithmetic display model.
module tb_seg_scan_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bin_in = '0;
  logic       bin_vld = 1'b0;

  logic       rdy_a, rdy_b, rdy_c, ovf_a, ovf_b, ovf_c;
  logic [7:0] led_a, led_b, led_c;
  logic [2:0] sel_a, sel_b;
  logic [1:0] sel_c;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cur = 0;

  always #5 clk = ~clk;

  seg_scan_bcd #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_vld(bin_vld),
    .bin_rdy(rdy_a), .ovf(ovf_a), .seg_led(led_a), .seg_sel(sel_a));
  seg_scan_bcd #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_vld(bin_vld),
    .bin_rdy(rdy_b), .ovf(ovf_b), .seg_led(led_b), .seg_sel(sel_b));
  seg_scan_bcd #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_vld(bin_vld),
    .bin_rdy(rdy_c), .ovf(ovf_c), .seg_led(led_c), .seg_sel(sel_c));

  function automatic logic [7:0] dec(int n);
    case (n)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int unsigned pow10(int e);
    int unsigned p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  // What digit i of a d-digit display shows for value v.
  function automatic logic [7:0] exp_led(int unsigned v, int d, int bl, int i);
    if (v >= pow10(d)) return 8'hBF;
    if (bl != 0 && i > 0 && v < pow10(i)) return 8'hFF;
    return dec((v / pow10(i)) % 10);
  endfunction

  // Index of the single low bit in the low d bits of sel, or -1.
  function automatic int sel_idx(logic [7:0] sel, int d);
    int cnt = 0;
    int idx = -1;
    for (int j = 0; j < d; j++) begin
      if (sel[j] == 1'b0) begin
        cnt++;
        idx = j;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic check_frame(string tag, int unsigned v);
    int ia, ib, ic;
    n_chk++;
    if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || ovf_c !== (v >= 100)) begin
      n_fail++;
      $display("FAIL %s ovf: got a=%b b=%b c=%b, expected a=0 b=0 c=%0d", tag, ovf_a, ovf_b, ovf_c, v >= 100);
    end
    repeat (12) begin
      @(negedge clk);
      ia = sel_idx({5'h1F, sel_a}, 3);
      ib = sel_idx({5'h1F, sel_b}, 3);
      ic = sel_idx({6'h3F, sel_c}, 2);
      n_chk++;
      if (ia < 0 || ib < 0 || ic < 0) begin
        n_fail++;
        $display("FAIL %s sel onehot: got a=%b b=%b c=%b, expected one low bit each", tag, sel_a, sel_b, sel_c);
      end else begin
        n_chk++;
        if (led_a !== exp_led(v, 3, 1, ia)) begin
          n_fail++;
          $display("FAIL %s led_a digit%0d v=%0d: got %h expected %h", tag, ia, v, led_a, exp_led(v, 3, 1, ia));
        end
        n_chk++;
        if (led_b !== exp_led(v, 3, 0, ib)) begin
          n_fail++;
          $display("FAIL %s led_b digit%0d v=%0d: got %h expected %h", tag, ib, v, led_b, exp_led(v, 3, 0, ib));
        end
        n_chk++;
        if (led_c !== exp_led(v, 2, 1, ic)) begin
          n_fail++;
          $display("FAIL %s led_c digit%0d v=%0d: got %h expected %h", tag, ic, v, led_c, exp_led(v, 2, 1, ic));
        end
      end
    end
  endtask

  // Accept v at the next edge; check busy window, old display held until the
  // load edge, then (optionally) a full frame of the new value.
  task automatic do_accept(string tag, int unsigned v, int unsigned old_v, bit frame);
    int ia;
    for (int k = 0; k < 50 && rdy_a !== 1'b1; k++) @(negedge clk);
    n_chk++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rdy timeout: got %b%b%b expected 111", tag, rdy_a, rdy_b, rdy_c);
    end
    bin_in  = 8'(v);
    bin_vld = 1'b1;
    @(negedge clk);
    bin_vld = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      ia = sel_idx({5'h1F, sel_a}, 3);
      n_chk++;
      if (rdy_a !== 1'b0 || rdy_c !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy T+%0d: got rdy_a=%b rdy_c=%b expected 0", tag, k, rdy_a, rdy_c);
      end
      n_chk++;
      if (ia < 0 || led_a !== exp_led(old_v, 3, 1, ia) || ovf_c !== (old_v >= 100)) begin
        n_fail++;
        $display("FAIL %s held T+%0d: got led=%h ovf_c=%b expected old value %0d", tag, k, led_a, ovf_c, old_v);
      end
    end
    @(negedge clk);
    ia = sel_idx({5'h1F, sel_a}, 3);
    n_chk++;
    if (rdy_a !== 1'b1 || ovf_c !== (v >= 100) || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load edge: got rdy=%b ovf_a=%b ovf_c=%b expected 1 0 %0d", tag, rdy_a, ovf_a, ovf_c, v >= 100);
    end
    n_chk++;
    if (ia < 0 || led_a !== exp_led(old_v, 3, 1, ia)) begin
      n_fail++;
      $display("FAIL %s output lag: got %h expected old value %0d digit", tag, led_a, old_v);
    end
    if (frame) begin
      @(negedge clk);
      check_frame(tag, v);
    end
  endtask

  task automatic test_reset();
    logic [2:0] prev;
    int run;
    bit first;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (rdy_a !== 1'b1 || ovf_a !== 1'b0 || sel_a !== 3'b110 || led_a !== 8'hC0 || sel_c !== 2'b10) begin
      n_fail++;
      $display("FAIL reset values: got rdy=%b ovf=%b sel=%b led=%h sel_c=%b expected 1 0 110 C0 10",
               rdy_a, ovf_a, sel_a, led_a, sel_c);
    end
    rst = 1'b0;
    prev  = sel_a;
    run   = 0;
    first = 1'b1;
    repeat (20) begin
      @(negedge clk);
      run++;
      if (sel_a !== prev) begin
        n_chk++;
        if (sel_a !== {prev[1:0], prev[2]}) begin
          n_fail++;
          $display("FAIL scan walk: got %b expected %b", sel_a, {prev[1:0], prev[2]});
        end
        if (!first) begin
          n_chk++;
          if (run != 4) begin
            n_fail++;
            $display("FAIL slot length: got %0d expected 4", run);
          end
        end
        first = 1'b0;
        prev  = sel_a;
        run   = 0;
      end
    end
    check_frame("reset_frame", 0);
    cur = 0;
  endtask

  task automatic test_known();
    int unsigned vals[6] = '{255, 7, 100, 5, 42, 0};
    foreach (vals[k]) begin
      do_accept("known", vals[k], cur, 1'b1);
      cur = vals[k];
    end
  endtask

  task automatic test_ignore();
    do_accept("ign_pre", 3, cur, 1'b1);
    bin_in  = 8'd255;
    bin_vld = 1'b1;
    @(negedge clk);
    bin_in = 8'd9;
    repeat (4) @(negedge clk);
    n_chk++;
    if (rdy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore busy: got rdy=%b expected 0", rdy_a);
    end
    bin_vld = 1'b0;
    for (int k = 0; k < 50 && rdy_a !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    check_frame("ignore", 255);
    cur = 255;
  endtask

  task automatic test_reset_mid();
    do_accept("mid_pre", 77, cur, 1'b1);
    bin_in  = 8'd255;
    bin_vld = 1'b1;
    @(negedge clk);
    bin_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (rdy_a !== 1'b1 || ovf_a !== 1'b0 || sel_a !== 3'b110 || led_a !== 8'hC0) begin
      n_fail++;
      $display("FAIL mid reset: got rdy=%b ovf=%b sel=%b led=%h expected 1 0 110 C0", rdy_a, ovf_a, sel_a, led_a);
    end
    @(negedge clk);
    rst = 1'b0;
    check_frame("after_reset", 0);
    do_accept("post_reset", 9, 0, 1'b1);
    cur = 9;
  endtask

  task automatic test_back_to_back();
    int unsigned v1 = $urandom_range(0, 255);
    int unsigned v2 = $urandom_range(0, 255);
    do_accept("b2b_first", v1, cur, 1'b0);
    do_accept("b2b_second", v2, v1, 1'b1);
    cur = v2;
  endtask

  task automatic test_random();
    int unsigned v;
    repeat (10) begin
      v = $urandom_range(0, 255);
      do_accept("random", v, cur, 1'b1);
      cur = v;
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
